motor_pwm_rampa: RTL and testbench

- Downstream stage of the ramp-start speed FSM: consumes its one-hot speed-level outputs (30 %, 50 %, 100 %) and drives the motor power stage with a PWM signal.
- Duty cycle is slew-limited: it moves toward the commanded level by a fixed step once per PWM period, never jumping.
- Flags illegal multi-hot level commands and forces a safe stop while one is present.

---
 rtl/motor_pkg.sv | 21 ++
 rtl/pwm_contador_periodo.sv | 28 ++
 rtl/motor_pwm_rampa.sv | 108 ++++++++++
 tb/tb_motor_pwm_rampa.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types and defaults for the motor PWM ramp stage.
// Holds the ramp state encoding, default level duties and the counter-width helper.
package motor_pkg;

  typedef enum logic [1:0] {
    PARADO,
    SUBIENDO,
    BAJANDO,
    ESTABLE
  } estado_rampa_t;

  localparam int DUTY_30_DEF  = 30;
  localparam int DUTY_50_DEF  = 50;
  localparam int DUTY_100_DEF = 100;

  // Width needed to hold every value 0..period, so duty=PERIOD is representable.
  function automatic int calc_cw(input int period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/pwm_contador_periodo.sv
// PWM period counter: counts 0..PERIOD-1 and wraps.
// fin_periodo marks the last cycle of each period.
module pwm_contador_periodo #(
  parameter int PERIOD = 100,
  parameter int CW     = 7
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] cnt,
  output logic          fin_periodo
);

  logic [CW-1:0] cnt_reg;

  assign fin_periodo = (cnt_reg == CW'(PERIOD - 1));
  assign cnt         = cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (fin_periodo) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/motor_pwm_rampa.sv
// Slew-limited motor PWM driven by one-hot speed-level commands.
// Duty moves toward the decoded target by at most STEP counts per PWM period.
module motor_pwm_rampa
  import motor_pkg::*;
#(
  parameter  int PERIOD   = 100,
  parameter  int STEP     = 5,
  parameter  int DUTY_30  = DUTY_30_DEF,
  parameter  int DUTY_50  = DUTY_50_DEF,
  parameter  int DUTY_100 = DUTY_100_DEF,
  localparam int CW       = calc_cw(PERIOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          out_30,
  input  logic          out_50,
  input  logic          out_100,
  output logic          pwm,
  output logic [CW-1:0] duty,
  output logic          en_rampa,
  output logic          estable,
  output logic          fin_periodo,
  output logic          fallo
);

  localparam logic [CW:0]   STEP_WIDE   = (CW + 1)'(STEP);
  localparam logic [CW-1:0] STEP_NARROW = CW'(STEP);

  logic [CW-1:0] cnt;
  logic [CW-1:0] target_reg, target_next;
  logic          fallo_reg, fallo_next;
  logic [CW-1:0] duty_reg, duty_next;
  logic [CW:0]   sum_up;
  logic [CW:0]   floor_down;
  estado_rampa_t state_reg, state_next;

  pwm_contador_periodo #(
    .PERIOD (PERIOD),
    .CW     (CW)
  ) u_contador (
    .clk         (clk),
    .reset       (reset),
    .cnt         (cnt),
    .fin_periodo (fin_periodo)
  );

  always_comb begin
    target_next = '0;
    fallo_next  = 1'b0;
    case ({out_100, out_50, out_30})
      3'b000:  target_next = '0;
      3'b001:  target_next = CW'(DUTY_30);
      3'b010:  target_next = CW'(DUTY_50);
      3'b100:  target_next = CW'(DUTY_100);
      default: fallo_next  = 1'b1;
    endcase
  end

  // One extra bit on both sides so neither the step-up sum nor the
  // step-down threshold can wrap before the clamp compare.
  assign sum_up     = {1'b0, duty_reg} + STEP_WIDE;
  assign floor_down = {1'b0, target_reg} + STEP_WIDE;

  always_comb begin
    duty_next = duty_reg;
    if (fin_periodo) begin
      if (target_reg > duty_reg) begin
        duty_next = (sum_up > {1'b0, target_reg}) ? target_reg : sum_up[CW-1:0];
      end else if (target_reg < duty_reg) begin
        duty_next = ({1'b0, duty_reg} < floor_down) ? target_reg : duty_reg - STEP_NARROW;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (duty_reg < target_reg) begin
      state_next = SUBIENDO;
    end else if (duty_reg > target_reg) begin
      state_next = BAJANDO;
    end else if (target_reg == '0) begin
      state_next = PARADO;
    end else begin
      state_next = ESTABLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_reg <= '0;
      fallo_reg  <= 1'b0;
      duty_reg   <= '0;
      state_reg  <= PARADO;
    end else begin
      target_reg <= target_next;
      fallo_reg  <= fallo_next;
      duty_reg   <= duty_next;
      state_reg  <= state_next;
    end
  end

  assign pwm      = (cnt < duty_reg);
  assign duty     = duty_reg;
  assign fallo    = fallo_reg;
  assign en_rampa = (state_reg == SUBIENDO) || (state_reg == BAJANDO);
  assign estable  = (state_reg == PARADO) || (state_reg == ESTABLE);

endmodule

// File: tb/tb_motor_pwm_rampa.sv
// Directed self-checking bench for motor_pwm_rampa.
// Default instance covers reset, ramps, reversal and faults; a STEP=7 instance covers clamping.
module tb_motor_pwm_rampa;

  logic       clk = 1'b0;
  logic       reset;
  logic       out_30, out_50, out_100;
  logic       pwm, en_rampa, estable, fin_periodo, fallo;
  logic [6:0] duty;

  logic       b_out_30, b_out_50, b_out_100;
  logic       b_pwm, b_en_rampa, b_estable, b_fin_periodo, b_fallo;
  logic [6:0] b_duty;

  int total = 0;
  int bad   = 0;
  int lows;

  always #5 clk = ~clk;

  motor_pwm_rampa dut (
    .clk         (clk),
    .reset       (reset),
    .out_30      (out_30),
    .out_50      (out_50),
    .out_100     (out_100),
    .pwm         (pwm),
    .duty        (duty),
    .en_rampa    (en_rampa),
    .estable     (estable),
    .fin_periodo (fin_periodo),
    .fallo       (fallo)
  );

  motor_pwm_rampa #(.STEP(7)) dut7 (
    .clk         (clk),
    .reset       (reset),
    .out_30      (b_out_30),
    .out_50      (b_out_50),
    .out_100     (b_out_100),
    .pwm         (b_pwm),
    .duty        (b_duty),
    .en_rampa    (b_en_rampa),
    .estable     (b_estable),
    .fin_periodo (b_fin_periodo),
    .fallo       (b_fallo)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    out_30    = 1'b0;
    out_50    = 1'b0;
    out_100   = 1'b1;
    b_out_30  = 1'b0;
    b_out_50  = 1'b1;
    b_out_100 = 1'b0;

    // Reset held with a command present
    step(3);
    check_val("rst_pwm", pwm, 0);
    check_val("rst_duty", duty, 0);
    check_val("rst_estable", estable, 1);
    check_val("rst_fallo", fallo, 0);
    check_val("rst_en_rampa", en_rampa, 0);
    check_val("rst_fin", fin_periodo, 0);

    // Release; edge k after release leaves cnt=k mod 100
    reset = 1'b1;
    step(99);
    check_val("first_fin", fin_periodo, 1);
    check_val("first_duty0", duty, 0);
    check_val("first_pwm0", pwm, 0);
    step(1);
    check_val("p1_duty", duty, 5);
    check_val("p1_fin_low", fin_periodo, 0);
    check_val("p1_en_rampa", en_rampa, 1);
    step(4);
    check_val("p1_pwm_cnt4", pwm, 1);
    step(1);
    check_val("p1_pwm_cnt5", pwm, 0);

    // Ramp up to 100
    step(95);
    check_val("ramp_k2", duty, 10);
    for (int k = 3; k <= 20; k++) begin
      step(100);
      check_val($sformatf("ramp_k%0d", k), duty, 5 * k);
    end
    step(1);
    check_val("full_estable", estable, 1);
    check_val("full_en_rampa", en_rampa, 0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (pwm !== 1'b1) lows++;
      step(1);
    end
    check_val("full_pwm_lows", lows, 0);

    // Reversal: ramp again to 60, then command 30 %
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1200);
    check_val("rev_duty60", duty, 60);
    out_100 = 1'b0;
    out_30  = 1'b1;
    step(2);
    check_val("rev_en_rampa", en_rampa, 1);
    check_val("rev_estable", estable, 0);
    step(98);
    check_val("rev_d1", duty, 55);
    for (int k = 2; k <= 6; k++) begin
      step(100);
      check_val($sformatf("rev_d%0d", k), duty, 60 - 5 * k);
    end
    step(100);
    check_val("rev_hold_duty", duty, 30);
    check_val("rev_hold_estable", estable, 1);

    // Multi-hot fault at duty 30
    out_50 = 1'b1;
    step(1);
    check_val("fault_fallo", fallo, 1);
    step(99);
    check_val("fault_d1", duty, 25);
    step(100);
    check_val("fault_d2", duty, 20);
    out_30 = 1'b0;
    step(1);
    check_val("fault_clear", fallo, 0);
    step(99);
    check_val("recover_d1", duty, 25);
    step(400);
    check_val("recover_d45", duty, 45);
    check_val("recover_pwm", pwm, 1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check_val("async_pwm", pwm, 0);
    check_val("async_duty", duty, 0);
    check_val("async_estable", estable, 1);
    check_val("async_en_rampa", en_rampa, 0);

    // Clamp on the STEP=7 instance, target 50
    step(2);
    reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(100);
      check_val($sformatf("clamp_k%0d", k), b_duty, (7 * k > 50) ? 50 : 7 * k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
